race_ctrl: RTL
==============

# race_ctrl

Race sequencing controller that sits directly upstream of the two-digit BCD race timer (rate divider plus display counter). Turns the player's start switch and the game's finish pulse into the timer's enable and active-low clear, runs a 3-2-1 pre-race countdown, captures the finishing time from the timer's BCD digits, and keeps a best-time record with a new-record strobe.

## Interface
- TICK_COUNT, 50000000, clock cycles per countdown second; legal range 2 to 2^28-1.
- COUNTDOWN_SECS, 3, first digit shown by the countdown; legal range 1 to 9.

- clock  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high; clears all state, including the best-time record.
- start  in  1  start switch level; only its rising edge acts.
- finish  in  1  one-cycle pulse from game logic when the player crosses the line.
- time_ones  in  4  timer ones digit (BCD, 0-9).
- time_tens  in  4  timer tens digit (BCD, 0-9).
- timer_enable  out  1  drives the timer's enable.
- timer_reset_n  out  1  drives the timer's active-low clear.
- countdown_digit  out  4  BCD digit for display; 0 when no countdown is running.
- state  out  2  current state: IDLE=0, COUNTDOWN=1, RACE=2, DONE=3.
- last_ones, last_tens  out  4 each  captured finishing time.
- best_ones, best_tens  out  4 each  best finishing time.
- best_valid  out  1  a best time has been recorded.
- timeout  out  1  the last race ended at 99 s without a finish.
- new_record  out  1  one-cycle strobe on a best-time update.

## Operation
- Start edge detect: register start into start_q each cycle. start_rise = start & ~start_q.
- Tick counter: 28 bits, runs only in COUNTDOWN. Counts 0 to TICK_COUNT-1, then wraps. The terminal count (TICK_COUNT-1) is the second tick.
- IDLE:
  - Outputs: timer_enable=0, timer_reset_n=0, countdown_digit=0.
  - On start_rise: go to COUNTDOWN; countdown_digit=COUNTDOWN_SECS; tick counter=0.
- COUNTDOWN:
  - Outputs: timer_enable=0, timer_reset_n=0.
  - On a second tick with countdown_digit>1: decrement countdown_digit.
  - On a second tick with countdown_digit==1: go to RACE; countdown_digit=0.
  - finish and start_rise are ignored.
- RACE:
  - Outputs: timer_enable=1, timer_reset_n=1.
  - On finish: go to DONE; last_* = time_* sampled that cycle; timeout=0.
  - Without finish, on time_tens==9 and time_ones==9: go to DONE; last_* = 9,9; timeout=1.
  - If both happen in the same cycle, finish wins: timeout=0 and the best-time update applies.
  - start_rise is ignored.
- DONE:
  - Outputs: timer_enable=0, timer_reset_n=1, so the timer display holds its value.
  - On start_rise: go to COUNTDOWN, exactly as from IDLE. The timer is cleared during the countdown.
- Best-time update (finish exits only):
  - Compare the sampled {time_tens,time_ones} as an 8-bit BCD value. BCD ordering equals numeric ordering.
  - If best_valid==0 or the sampled time is less than best: best_* = sampled time, best_valid=1, new_record=1 for one cycle.
  - An equal time is not a record.
  - A timeout exit never updates best.
- reset (any state, including mid-countdown or mid-race):
  - Next state IDLE, tick counter=0, start_q=0.
  - All outputs go to their reset values.

## Timing
- Reset values:
  - state=IDLE, timer_enable=0, timer_reset_n=0, countdown_digit=0.
  - last_*=0, best_*=0, best_valid=0, timeout=0, new_record=0.
- All outputs are registered or decoded from registered state; none are combinational from inputs.
- start_rise on cycle N: state=COUNTDOWN and countdown_digit=COUNTDOWN_SECS from cycle N+1.
- Countdown length:
  - Each digit is held for exactly TICK_COUNT cycles.
  - RACE is entered COUNTDOWN_SECS*TICK_COUNT cycles after entering COUNTDOWN.
- finish on cycle N: from cycle N+1, state=DONE, timer_enable=0 and last_* are valid. new_record is high during cycle N+1 only.
- A start held high across a state change does not re-trigger. A new rising edge is required.

## Test plan
- Reset, then TICK_COUNT=4, COUNTDOWN_SECS=3:
  - Stimulus: pulse start.
  - Required: countdown_digit reads 3,3,3,3,2,2,2,2,1,1,1,1; RACE is entered on the next cycle with timer_enable=1 and timer_reset_n=1.
- First race:
  - Stimulus: in RACE, drive time=1,7 and pulse finish.
  - Required: next cycle state=DONE, last=17, best=17, best_valid=1, new_record high for exactly 1 cycle.
- Second and third races:
  - Stimulus: second race finishes at 23, then a third finishes at 17.
  - Required: best stays 17 and new_record stays 0 both times.
  - Stimulus: a fourth race finishes at 09.
  - Required: best=09 and new_record pulses.
- Timeout:
  - Stimulus: in RACE, drive time=9,9 with no finish.
  - Required: DONE, timeout=1, last=99, best unchanged.
  - Stimulus: repeat with finish asserted in the same cycle as 9,9.
  - Required: timeout=0, and best updates if best_valid=0.
- Ignored events and start edge:
  - Stimulus: finish pulse during COUNTDOWN.
  - Required: ignored.
  - Stimulus: start toggled during RACE.
  - Required: ignored.
  - Stimulus: start held high from IDLE into DONE.
  - Required: no restart until start falls and rises again.
- Mid-operation reset:
  - Stimulus: assert reset mid-countdown; separately, assert it in DONE with best_valid=1.
  - Required: next cycle state=IDLE, countdown_digit=0, timer_reset_n=0, best_valid=0, best=00.

Source files
------------

// File: rtl/race_ctrl.sv
// Race sequencing controller: start/finish handling, 3-2-1 countdown, finishing-time
// capture and best-time record for a two-digit BCD race timer.
module race_ctrl #(
    parameter int TICK_COUNT     = 50000000,
    parameter int COUNTDOWN_SECS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       finish,
    input  logic [3:0] time_ones,
    input  logic [3:0] time_tens,
    output logic       timer_enable,
    output logic       timer_reset_n,
    output logic [3:0] countdown_digit,
    output logic [1:0] state,
    output logic [3:0] last_ones,
    output logic [3:0] last_tens,
    output logic [3:0] best_ones,
    output logic [3:0] best_tens,
    output logic       best_valid,
    output logic       timeout,
    output logic       new_record
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_RACE      = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [27:0] TICK_LAST = 28'(TICK_COUNT - 1);
    localparam logic [3:0]  FIRST_DIGIT = 4'(COUNTDOWN_SECS);

    logic [1:0]  state_q, state_d;
    logic        start_q;
    logic [27:0] tick_q, tick_d;
    logic [3:0]  digit_q, digit_d;
    logic [3:0]  last_ones_q, last_ones_d;
    logic [3:0]  last_tens_q, last_tens_d;
    logic [3:0]  best_ones_q, best_ones_d;
    logic [3:0]  best_tens_q, best_tens_d;
    logic        best_valid_q, best_valid_d;
    logic        timeout_q, timeout_d;
    logic        new_record_q, new_record_d;

    logic start_rise;
    logic second_tick;
    logic at_99;
    logic is_record;

    assign start_rise  = start & ~start_q;
    assign second_tick = (tick_q == TICK_LAST);
    assign at_99       = (time_tens == 4'd9) && (time_ones == 4'd9);
    // BCD digits packed tens-first compare exactly like the numeric value.
    assign is_record   = !best_valid_q ||
                         ({time_tens, time_ones} < {best_tens_q, best_ones_q});

    always_comb begin
        state_d      = state_q;
        tick_d       = 28'd0;
        digit_d      = digit_q;
        last_ones_d  = last_ones_q;
        last_tens_d  = last_tens_q;
        best_ones_d  = best_ones_q;
        best_tens_d  = best_tens_q;
        best_valid_d = best_valid_q;
        timeout_d    = timeout_q;
        new_record_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_d = ST_COUNTDOWN;
                    digit_d = FIRST_DIGIT;
                end
            end
            ST_COUNTDOWN: begin
                tick_d = second_tick ? 28'd0 : tick_q + 28'd1;
                if (second_tick) begin
                    if (digit_q > 4'd1) begin
                        digit_d = digit_q - 4'd1;
                    end else begin
                        state_d = ST_RACE;
                        digit_d = 4'd0;
                    end
                end
            end
            default: begin
                // A finish in the same cycle as 99 s beats the timeout.
                if (finish) begin
                    state_d     = ST_DONE;
                    last_ones_d = time_ones;
                    last_tens_d = time_tens;
                    timeout_d   = 1'b0;
                    if (is_record) begin
                        best_ones_d  = time_ones;
                        best_tens_d  = time_tens;
                        best_valid_d = 1'b1;
                        new_record_d = 1'b1;
                    end
                end else if (at_99) begin
                    state_d     = ST_DONE;
                    last_ones_d = 4'd9;
                    last_tens_d = 4'd9;
                    timeout_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            tick_q       <= 28'd0;
            digit_q      <= 4'd0;
            last_ones_q  <= 4'd0;
            last_tens_q  <= 4'd0;
            best_ones_q  <= 4'd0;
            best_tens_q  <= 4'd0;
            best_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            tick_q       <= tick_d;
            digit_q      <= digit_d;
            last_ones_q  <= last_ones_d;
            last_tens_q  <= last_tens_d;
            best_ones_q  <= best_ones_d;
            best_tens_q  <= best_tens_d;
            best_valid_q <= best_valid_d;
            timeout_q    <= timeout_d;
            new_record_q <= new_record_d;
        end
    end

    // Timer stays cleared until the race runs, then holds its value in DONE.
    assign timer_enable    = (state_q == ST_RACE);
    assign timer_reset_n   = (state_q == ST_RACE) || (state_q == ST_DONE);
    assign countdown_digit = digit_q;
    assign state           = state_q;
    assign last_ones       = last_ones_q;
    assign last_tens       = last_tens_q;
    assign best_ones       = best_ones_q;
    assign best_tens       = best_tens_q;
    assign best_valid      = best_valid_q;
    assign timeout         = timeout_q;
    assign new_record      = new_record_q;

endmodule
